// File: rtl/alu_demux_collector.sv
// Bit-serial 1:8 demultiplexer: steers accepted bits into an 8-lane accumulator
// and presents each completed word through a one-deep valid/ready slot. Optional: ALU_DEMUX_ADDR_EN.
module alu_demux_collector #(
   parameter int LANES = 8,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_bit,
`ifdef ALU_DEMUX_ADDR_EN
   input  logic [SEL_W-1:0] in_sel,
   input  logic [0:0]       in_last,
`endif
   output logic [LANES-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LANES-1:0] lane_strobe,
   output logic [SEL_W-1:0] lane_count
);

   localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);

   logic [LANES-1:0] acc_q, acc_d;
   logic [SEL_W-1:0] lane_count_q, lane_count_d;
   logic [LANES-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;

   logic             pop_s;
   logic             stall_s;
   logic             accept_s;
   logic             last_s;
   logic [SEL_W-1:0] wr_idx_s;
   logic [SEL_W-1:0] cnt_inc_s;
   logic [LANES-1:0] word_s;

   // Handshake decode, write-lane selection and one-hot demux strobe.
   always_comb begin
      pop_s = out_valid_q && out_ready;
`ifdef ALU_DEMUX_ADDR_EN
      wr_idx_s  = in_sel;
      last_s    = in_last[0];
      stall_s   = in_valid && in_last[0] && out_valid_q && !out_ready;
      cnt_inc_s = (lane_count_q == LAST_LANE) ? LAST_LANE : lane_count_q + SEL_W'(1);
`else
      wr_idx_s  = lane_count_q;
      last_s    = (lane_count_q == LAST_LANE);
      stall_s   = last_s && out_valid_q && !out_ready;
      cnt_inc_s = lane_count_q + SEL_W'(1);
`endif
      in_ready    = !stall_s;
      accept_s    = in_valid && in_ready && !reset;
      lane_strobe = {LANES{1'b0}};
      if (accept_s) begin
         lane_strobe[wr_idx_s] = 1'b1;
      end else begin
         lane_strobe = {LANES{1'b0}};
      end
   end

   // Next state: a completion moves the merged word to the output slot in the
   // same cycle a pop frees it, so back-to-back words see no bubble.
   always_comb begin
      acc_d        = acc_q;
      lane_count_d = lane_count_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      word_s       = acc_q;
      word_s[wr_idx_s] = in_bit;
      if (pop_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      if (accept_s && last_s) begin
         out_data_d   = word_s;
         out_valid_d  = 1'b1;
         acc_d        = {LANES{1'b0}};
         lane_count_d = {SEL_W{1'b0}};
      end else if (accept_s) begin
         acc_d        = word_s;
         lane_count_d = cnt_inc_s;
      end else begin
         acc_d        = acc_q;
         lane_count_d = lane_count_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q        <= {LANES{1'b0}};
         lane_count_q <= {SEL_W{1'b0}};
         out_data_q   <= {LANES{1'b0}};
         out_valid_q  <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         lane_count_q <= lane_count_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign lane_count = lane_count_q;

endmodule
